// File: rtl/bist_result_checker.sv
// Response compactor for the BIST controller: folds the serial OUT stream into a
// SISR while RUNNING is high and reports a registered pass/fail/timeout verdict.
module bist_result_checker #(
   parameter int                   SIG_WIDTH  = 16,
   parameter logic [SIG_WIDTH-1:0] POLY       = 16'h1021,
   parameter logic [SIG_WIDTH-1:0] SEED       = 16'hFFFF,
   parameter logic [SIG_WIDTH-1:0] GOLDEN     = 16'h0000,
   parameter int                   MAX_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 running,
   input  logic                 bist_end,
   input  logic                 out_bit,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 fail,
   output logic                 timeout,
   output logic [SIG_WIDTH-1:0] signature,
   output logic [15:0]          bit_count
);

   localparam int CW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, CHECK, DONE} state_t;

   state_t               state;
   logic [CW-1:0]        cycle_cnt;
   logic                 fb;
   logic [SIG_WIDTH-1:0] sig_next;

   always_comb begin
      fb       = signature[SIG_WIDTH-1] ^ out_bit;
      sig_next = {signature[SIG_WIDTH-2:0], 1'b0} ^ ({SIG_WIDTH{fb}} & POLY);
   end

   // NOTE: every register here is written with <= so all state updates see the
   // pre-edge values; blocking assignments would make ordering matter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timeout   <= 1'b0;
         signature <= SEED;
         bit_count <= '0;
         cycle_cnt <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= ARMED;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  fail      <= 1'b0;
                  timeout   <= 1'b0;
                  signature <= SEED;
                  bit_count <= '0;
                  cycle_cnt <= '0;
               end
            end
            ARMED, CAPTURE: begin
               if (running) begin
                  signature <= sig_next;
                  if (bit_count != 16'hFFFF) bit_count <= bit_count + 16'd1;
               end
               // bist_end on the final counted cycle still earns a real verdict
               if (bist_end) begin
                  state <= CHECK;
               end else if (cycle_cnt == LAST_CYCLE) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  pass    <= 1'b0;
                  fail    <= 1'b1;
                  timeout <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
                  if (running) state <= CAPTURE;
               end
            end
            CHECK: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (signature == GOLDEN);
               fail  <= (signature != GOLDEN);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bist_result_checker.sv
// Scoreboard bench for bist_result_checker: expected verdicts are queued as each run
// is driven and retired by a monitor when done rises.
module tb_bist_result_checker;

   localparam int         W      = 4;
   localparam logic [3:0] POLY   = 4'h3;
   localparam logic [3:0] SEED   = 4'h0;
   localparam logic [3:0] GOLDEN = 4'hE;
   localparam int         MAXC   = 20;

   logic        clk = 1'b0;
   logic        rst, start, running, bist_end, out_bit;
   logic        busy, done, pass, fail, timeout;
   logic [3:0]  signature;
   logic [15:0] bit_count;

   bist_result_checker #(
      .SIG_WIDTH(W), .POLY(POLY), .SEED(SEED), .GOLDEN(GOLDEN), .MAX_CYCLES(MAXC)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .running(running), .bist_end(bist_end),
      .out_bit(out_bit), .busy(busy), .done(done), .pass(pass), .fail(fail),
      .timeout(timeout), .signature(signature), .bit_count(bit_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pass;
      logic        fail;
      logic        timeout;
      logic [3:0]  sig;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [3:0] sisr_ref(input logic [3:0] s, input logic b);
      logic f;
      f = s[3] ^ b;
      return {s[2:0], 1'b0} ^ ({4{f}} & POLY);
   endfunction

   // bits[0] is the first bit shifted in
   function automatic logic [3:0] run_ref(input logic [7:0] bits, input int n);
      logic [3:0] s;
      s = SEED;
      for (int i = 0; i < n; i++) s = sisr_ref(s, bits[i]);
      return s;
   endfunction

   function automatic exp_t mk(input logic p, input logic f, input logic t,
                               input logic [3:0] s, input logic [15:0] c);
      exp_t e;
      e.pass = p; e.fail = f; e.timeout = t; e.sig = s; e.cnt = c;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic arm();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic b, input logic last);
      running  = 1'b1;
      out_bit  = b;
      bist_end = last;
      step();
      running  = 1'b0;
      out_bit  = 1'b0;
      bist_end = 1'b0;
   endtask

   // Verdict monitor and output invariants
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         total++;
         if ((pass && fail) || (!done && (pass || fail))) begin
            bad++;
            $display("FAIL invariant: done=%b pass=%b fail=%b", done, pass, fail);
         end
         if (done && !prev_done) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL verdict: unexpected done with empty scoreboard");
            end else begin
               exp_t e;
               e = sb.pop_front();
               if ({pass, fail, timeout, signature, bit_count} !== e) begin
                  bad++;
                  $display("FAIL verdict: got p=%b f=%b t=%b sig=%h cnt=%0d want p=%b f=%b t=%b sig=%h cnt=%0d",
                           pass, fail, timeout, signature, bit_count,
                           e.pass, e.fail, e.timeout, e.sig, e.cnt);
               end
            end
         end
      end
      prev_done = done;
   end

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; running = 1'b0; bist_end = 1'b0; out_bit = 1'b0;
      step(); step();
      rst = 1'b0;
      total++;
      if ({busy, done, pass, fail, timeout, signature, bit_count} !== {5'b0, SEED, 16'd0}) begin
         bad++;
         $display("FAIL reset: busy=%b done=%b pass=%b fail=%b to=%b sig=%h cnt=%0d",
                  busy, done, pass, fail, timeout, signature, bit_count);
      end
   endtask

   task automatic test_pass();
      arm();
      total++;
      if ({busy, done} !== 2'b10) begin
         bad++; $display("FAIL arm_busy: busy=%b done=%b want busy=1 done=0", busy, done);
      end
      sb.push_back(mk(1'b1, 1'b0, 1'b0, run_ref(8'b1101, 4), 16'd4));
      send(1, 0); send(0, 0); send(1, 0); send(1, 1);
      total++;
      if ({done, signature, bit_count} !== {1'b0, 4'hE, 16'd4}) begin
         bad++;
         $display("FAIL pass_check_cycle: done=%b sig=%h cnt=%0d want done=0 sig=e cnt=4",
                  done, signature, bit_count);
      end
      step();
      total++;
      if ({done, pass, fail, busy} !== 4'b1100) begin
         bad++;
         $display("FAIL pass_latency: done=%b pass=%b fail=%b busy=%b want 1 1 0 0",
                  done, pass, fail, busy);
      end
   endtask

   task automatic test_fail();
      arm();
      total++;
      if ({done, busy, signature, bit_count} !== {2'b01, SEED, 16'd0}) begin
         bad++;
         $display("FAIL rearm_from_done: done=%b busy=%b sig=%h cnt=%0d", done, busy, signature, bit_count);
      end
      sb.push_back(mk(1'b0, 1'b1, 1'b0, run_ref(8'b0101, 4), 16'd4));
      send(1, 0); send(0, 0); send(1, 0); send(0, 1);
      step();
      total++;
      if ({done, pass, fail, timeout} !== 4'b1010) begin
         bad++;
         $display("FAIL mismatch_verdict: done=%b pass=%b fail=%b to=%b want 1 0 1 0",
                  done, pass, fail, timeout);
      end
   endtask

   task automatic test_timeout();
      int k;
      arm();
      sb.push_back(mk(1'b0, 1'b1, 1'b1, SEED, 16'd0));
      k = 0;
      for (int i = 1; i <= 2 * MAXC; i++) begin
         step();
         if (done) begin k = i; break; end
      end
      total++;
      if (k !== MAXC) begin
         bad++; $display("FAIL timeout_edge: done after %0d edges, want %0d", k, MAXC);
      end
      total++;
      if ({done, fail, timeout, pass, busy} !== 5'b11100) begin
         bad++;
         $display("FAIL timeout_flags: done=%b fail=%b to=%b pass=%b busy=%b want 1 1 1 0 0",
                  done, fail, timeout, pass, busy);
      end
   endtask

   task automatic test_gap();
      logic [3:0] mid;
      mid = run_ref(8'b01, 2);
      arm();
      sb.push_back(mk(1'b1, 1'b0, 1'b0, run_ref(8'b1101, 4), 16'd4));
      send(1, 0); send(0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if ({signature, bit_count} !== {mid, 16'd2}) begin
            bad++;
            $display("FAIL gap_hold[%0d]: sig=%h cnt=%0d want sig=%h cnt=2", i, signature, bit_count, mid);
         end
      end
      send(1, 0); send(1, 1);
      step();
      total++;
      if ({done, pass} !== 2'b11) begin
         bad++; $display("FAIL gap_verdict: done=%b pass=%b want 1 1", done, pass);
      end
   endtask

   task automatic test_reset_mid();
      arm();
      send(1, 0); send(0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if ({busy, done, pass, fail, timeout, signature, bit_count} !== {5'b0, SEED, 16'd0}) begin
         bad++;
         $display("FAIL reset_mid: busy=%b done=%b pass=%b fail=%b to=%b sig=%h cnt=%0d",
                  busy, done, pass, fail, timeout, signature, bit_count);
      end
      arm();
      sb.push_back(mk(1'b1, 1'b0, 1'b0, run_ref(8'b1101, 4), 16'd4));
      send(1, 0); send(0, 0); send(1, 0); send(1, 1);
      step();
      total++;
      if ({done, pass, fail} !== 3'b110) begin
         bad++; $display("FAIL post_reset_run: done=%b pass=%b fail=%b want 1 1 0", done, pass, fail);
      end
   endtask

   task automatic test_back_to_back();
      arm();
      sb.push_back(mk(1'b1, 1'b0, 1'b0, run_ref(8'b1101, 4), 16'd4));
      send(1, 0); send(0, 0);
      start = 1'b1;
      send(1, 0);
      start = 1'b0;
      total++;
      if ({busy, signature, bit_count} !== {1'b1, run_ref(8'b101, 3), 16'd3}) begin
         bad++;
         $display("FAIL start_in_capture: busy=%b sig=%h cnt=%0d want busy=1 sig=%h cnt=3",
                  busy, signature, bit_count, run_ref(8'b101, 3));
      end
      send(1, 1);
      step();
      total++;
      if ({done, pass} !== 2'b11) begin
         bad++; $display("FAIL ignored_start_verdict: done=%b pass=%b want 1 1", done, pass);
      end
      // re-arm from DONE, then end the run empty
      arm();
      total++;
      if ({done, bit_count} !== {1'b0, 16'd0}) begin
         bad++; $display("FAIL start_in_done: done=%b cnt=%0d want 0 0", done, bit_count);
      end
      sb.push_back(mk(1'b0, 1'b1, 1'b0, SEED, 16'd0));
      bist_end = 1'b1;
      step();
      bist_end = 1'b0;
      step();
      total++;
      if ({done, fail, signature} !== {2'b11, SEED}) begin
         bad++; $display("FAIL empty_run: done=%b fail=%b sig=%h want 1 1 %h", done, fail, signature, SEED);
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_fail();
      test_timeout();
      test_gap();
      test_reset_mid();
      test_back_to_back();
      step(); step();
      total++;
      if (sb.size() !== 0) begin
         bad++; $display("FAIL scoreboard_drain: %0d verdicts never produced", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
